// File: rtl/ifetch_pkg.sv
// Shared types and constants for the byte-serial RV32IC fetch stage.
// Imported by ifetch_align and ifetch_shiftbuf.
package ifetch_pkg;

  typedef enum logic [2:0] {
    B0,
    B1,
    B2,
    B3,
    HOLD
  } fetch_state_t;

  localparam logic [1:0] OPC_FULL = 2'b11;
  localparam int ILEN_C  = 2;
  localparam int ILEN_32 = 4;

  function automatic logic [1:0] byte_idx(input fetch_state_t s);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (s)
      B1:      idx = 2'd1;
      B2:      idx = 2'd2;
      B3:      idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ifetch_shiftbuf.sv
// Byte-lane instruction buffer; writing lane 0 also zeroes the upper
// lanes so a compressed instruction always reads back zero-extended.
module ifetch_shiftbuf
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_we,
  input  logic [1:0]  i_idx,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word
);

  logic [31:0] r_word;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_word <= '0;
    end else if (i_clr) begin
      r_word <= '0;
    end else if (i_we) begin
      unique case (i_idx)
        2'd0: r_word         <= {24'h0, i_byte};
        2'd1: r_word[15:8]   <= i_byte;
        2'd2: r_word[23:16]  <= i_byte;
        2'd3: r_word[31:24]  <= i_byte;
      endcase
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/ifetch_align.sv
// Byte-serial fetch: reads one byte per cycle, assembles an RV32IC
// instruction and hands it to decode over valid/ready with redirects.
module ifetch_align
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_oe,
  output logic              imem_we,
  input  logic [7:0]        imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_c
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;
  logic              r_c;

  logic [1:0]        w_idx;
  logic [31:0]       w_word;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_len;
  logic              w_unused_rpc0;

  assign w_idx   = byte_idx(r_state);
  assign w_fetch = (r_state != HOLD);
  assign w_len   = r_c ? ADDR_W'(ILEN_C)
                       : ADDR_W'(ILEN_32);

  // bit 0 of a redirect target is dropped
  assign w_unused_rpc0 = redirect_pc[0];

  ifetch_shiftbuf u_buf (
    .clk    (clk),
    .i_rst  (reset),
    .i_clr  (redirect_valid),
    .i_we   (w_fetch),
    .i_idx  (w_idx),
    .i_byte (imem_rdata),
    .o_word (w_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= B0;
      r_pc       <= RESET_PC;
      r_valid    <= 1'b0;
      r_instr_pc <= '0;
      r_c        <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[ADDR_W-1:1], 1'b0};
      r_state <= B0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        B0: r_state <= B1;
        B1: begin
          if (w_word[1:0] != OPC_FULL) begin
            r_state    <= HOLD;
            r_valid    <= 1'b1;
            r_c        <= 1'b1;
            r_instr_pc <= r_pc;
          end else begin
            r_state <= B2;
          end
        end
        B2: r_state <= B3;
        B3: begin
          r_state    <= HOLD;
          r_valid    <= 1'b1;
          r_c        <= 1'b0;
          r_instr_pc <= r_pc;
        end
        HOLD: begin
          if (instr_ready) begin
            r_pc    <= r_pc + w_len;
            r_state <= B0;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= B0;
      endcase
    end
  end

  assign imem_addr   = r_pc + ADDR_W'(w_idx);
  assign imem_oe     = w_fetch & ~reset;
  assign imem_we     = 1'b0;
  assign instr_valid = r_valid;
  assign instr       = w_word;
  assign instr_pc    = r_instr_pc;
  assign instr_c     = r_c;

endmodule

// File: tb/tb_ifetch_align.sv
// Self-checking bench for ifetch_align: transaction-level model plus
// directed literal checks and randomized ready/redirect traffic.
module tb_ifetch_align;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic        imem_oe;
  logic        imem_we;
  logic [7:0]  imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_c;

  logic [7:0]  mem [256];
  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_pc;
  int          m_el;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  ifetch_align dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_oe        (imem_oe),
    .imem_we        (imem_we),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_c        (instr_c)
  );

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  function automatic int m_len();
    return (mem[m_pc][1:0] == 2'b11) ? 4 : 2;
  endfunction

  function automatic logic [31:0] m_word();
    logic [31:0] w;
    w = {24'h0, mem[m_pc]};
    w[15:8] = mem[8'(m_pc + 8'd1)];
    if (m_len() == 4) begin
      w[23:16] = mem[8'(m_pc + 8'd2)];
      w[31:24] = mem[8'(m_pc + 8'd3)];
    end
    return w;
  endfunction

  task automatic compare();
    int len;
    len = m_len();
    chk("we", 32'(imem_we), 32'd0);
    chk("oe", 32'(imem_oe), 32'(m_el < len));
    if (m_el < len)
      chk("addr", 32'(imem_addr), 32'(8'(m_pc + 8'(m_el))));
    chk("valid", 32'(instr_valid), 32'(m_el >= len));
    if (m_el >= len) begin
      chk("instr", instr, m_word());
      chk("instr_pc", 32'(instr_pc), 32'(m_pc));
      chk("instr_c", 32'(instr_c), 32'(len == 2));
    end
  endtask

  task automatic model_edge(input logic rdy, input logic rv,
                            input logic [7:0] rpc);
    int len;
    len = m_len();
    if (rv) begin
      m_pc = rpc & 8'hFE;
      m_el = 0;
    end else if (m_el >= len) begin
      if (rdy) begin
        m_pc = m_pc + 8'(len);
        m_el = 0;
      end
    end else begin
      m_el++;
    end
  endtask

  task automatic cyc(input logic rdy, input logic rv,
                     input logic [7:0] rpc);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    model_edge(rdy, rv, rpc);
    @(negedge clk);
    compare();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    m_pc  = 8'h00;
    m_el  = 0;
    #1;
    compare();
  endtask

  initial begin
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
    mem[8'h00] = 8'h13; mem[8'h01] = 8'h05;
    mem[8'h02] = 8'h00; mem[8'h03] = 8'h00;
    mem[8'h04] = 8'h01; mem[8'h05] = 8'h45;
    mem[8'h06] = 8'h13; mem[8'h07] = 8'h00;
    mem[8'h08] = 8'h00; mem[8'h09] = 8'h00;
    mem[8'h20] = 8'h13; mem[8'h21] = 8'h00;
    mem[8'h22] = 8'h00; mem[8'h23] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oe", 32'(imem_oe), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    release_reset();

    // 32-bit addi at 0x00
    repeat (4) cyc(1'b1, 1'b0, 8'h00);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_instr", instr, 32'h00000513);
    chk("t1_pc", 32'(instr_pc), 32'h00);
    chk("t1_c", 32'(instr_c), 32'd0);
    cyc(1'b1, 1'b0, 8'h00);
    chk("t1_next", 32'(imem_addr), 32'h04);

    // c.li at 0x04, then stall decode
    repeat (2) cyc(1'b1, 1'b0, 8'h00);
    chk("t2_instr", instr, 32'h00004501);
    chk("t2_c", 32'(instr_c), 32'd1);
    chk("t2_pc", 32'(instr_pc), 32'h04);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      chk("hold_instr", instr, 32'h00004501);
      chk("hold_oe", 32'(imem_oe), 32'd0);
    end
    cyc(1'b1, 1'b0, 8'h00);
    chk("t3_valid", 32'(instr_valid), 32'd0);
    chk("t3_addr", 32'(imem_addr), 32'h06);

    // redirect in B2 of a 32-bit fetch
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("t4_b2", 32'(imem_addr), 32'h08);
    cyc(1'b0, 1'b1, 8'h21);
    chk("t4_addr", 32'(imem_addr), 32'h20);
    chk("t4_valid", 32'(instr_valid), 32'd0);
    repeat (4) cyc(1'b0, 1'b0, 8'h00);
    chk("t5_valid", 32'(instr_valid), 32'd1);
    cyc(1'b1, 1'b1, 8'h21);
    chk("t5_addr", 32'(imem_addr), 32'h20);
    chk("t5_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 8'h40);
      chk("rdir_held", 32'(imem_addr), 32'h40);
    end

    // wrap-around fetch at 0xFE
    mem[8'hFE] = 8'h93; mem[8'hFF] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h00;
    cyc(1'b0, 1'b1, 8'hFE);
    chk("wr_a0", 32'(imem_addr), 32'hFE);
    cyc(1'b0, 1'b0, 8'h00);
    chk("wr_a1", 32'(imem_addr), 32'hFF);
    cyc(1'b0, 1'b0, 8'h00);
    chk("wr_a2", 32'(imem_addr), 32'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("wr_a3", 32'(imem_addr), 32'h01);
    cyc(1'b0, 1'b0, 8'h00);
    chk("wr_instr", instr, 32'h00100093);
    cyc(1'b1, 1'b0, 8'h00);
    chk("wr_next", 32'(imem_addr), 32'h02);

    // async reset in B1
    cyc(1'b0, 1'b1, 8'h10);
    cyc(1'b0, 1'b0, 8'h00);
    chk("b1_oe", 32'(imem_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_oe", 32'(imem_oe), 32'd0);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    release_reset();
    chk("arst_addr", 32'(imem_addr), 32'h00);

    // async reset in HOLD (0x00 now compressed)
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("h_valid", 32'(instr_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arsth_valid", 32'(instr_valid), 32'd0);
    chk("arsth_instr", instr, 32'd0);
    chk("arsth_pc", 32'(instr_pc), 32'd0);
    release_reset();

    // randomized traffic over random memory
    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0,
          8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_align.md
Name: ifetch_align

Overview:
- Fetch stage directly downstream of the byte-wide instruction memory (8-bit address, 8-bit data, combinational read while oe=1 and we=0).
- Each cycle it reads one byte sequentially from the current PC.
- It assembles the bytes little-endian into one RV32IC instruction, either 16-bit compressed or 32-bit.
- It presents the instruction to decode over a valid/ready handshake, advances the PC by 2 or 4, and accepts branch/jump redirects.

Parameters:
- ADDR_W, 8, width of PC and memory byte address.
- RESET_PC, 8'h00, PC loaded on reset. Bit 0 must be 0.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- imem_addr, output, ADDR_W, byte address to instruction memory.
- imem_oe, output, 1, memory read enable.
- imem_we, output, 1, memory write enable. Constant 0.
- imem_rdata, input, 8, byte returned combinationally by memory for imem_addr.
- redirect_valid, input, 1, PC redirect request (taken branch/jump).
- redirect_pc, input, ADDR_W, redirect target. Bit 0 is ignored (forced 0).
- instr_valid, output, 1, instr/instr_pc/instr_c hold a complete instruction.
- instr_ready, input, 1, decode accepts the instruction this cycle.
- instr, output, 32, assembled instruction. Upper 16 bits are zero when compressed.
- instr_pc, output, ADDR_W, address of the instruction's first byte.
- instr_c, output, 1, 1 = 16-bit compressed instruction.

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC, state=B0, byte index cleared.
  - instr_valid=0, instr=0, instr_pc=0, instr_c=0.
  - imem_oe=0 while reset is asserted.
  - A partially assembled instruction is discarded.
- FSM states:
  - B0, B1, B2, B3: capture byte n at the rising edge.
  - HOLD: output valid, waiting for instr_ready.
- Addressing:
  - imem_addr = pc + n (mod 2^ADDR_W) in state Bn.
  - imem_oe = 1 in B0..B3 and 0 in HOLD; imem_we is always 0.
- Transitions:
  - B0 -> B1, capturing instr[7:0].
  - B1 -> HOLD if instr[1:0] != 2'b11, capturing instr[15:8]; set instr_c=1 and instr[31:16]=0.
  - B1 -> B2 otherwise, capturing instr[15:8].
  - B2 -> B3, capturing instr[23:16].
  - B3 -> HOLD, capturing instr[31:24]; set instr_c=0.
- instr_valid is registered: it is 1 exactly in HOLD.
- Latency from entering B0: compressed valid on the 3rd edge, 32-bit valid on the 5th edge.
- Encodings with instr[1:0]==11 (including the reserved ≥48-bit forms) are treated as 32-bit. No error flag.
- Handshake:
  - In HOLD with instr_ready=1: pc <= pc + (instr_c ? 2 : 4), state <= B0, instr_valid drops on the next edge.
  - In HOLD with instr_ready=0: instr, instr_pc and instr_c are held stable, with no memory reads.
  - Back-to-back throughput: 1 instruction per 3 cycles (C) or 5 cycles (32-bit).
- Redirect:
  - redirect_valid=1 in any state has highest priority, over instr_ready, at the same edge.
  - Action: pc <= {redirect_pc[ADDR_W-1:1],1'b0}, state <= B0, instr_valid <= 0.
  - A held or partial instruction is discarded; a simultaneous instr_ready is ignored.
  - A redirect held for several cycles keeps reloading pc and restarting B0.
- Wrap-around:
  - PC and byte addresses wrap modulo 256.
  - A 32-bit instruction at 0xFE reads bytes 0xFE, 0xFF, 0x00, 0x01; the next pc is 0x02.
  - A compressed instruction at 0xFE gives next pc 0x00.
- instr_pc is latched from pc on entry to HOLD.

Decomposition:
- Package ifetch_pkg holds:
  - state enum typedef fetch_state_t {B0,B1,B2,B3,HOLD};
  - localparam OPC_FULL = 2'b11;
  - localparam ILEN_C = 2 and ILEN_32 = 4.
- A single optional sub-module, ifetch_shiftbuf, is natural: a byte-lane write buffer that takes a byte index and byte and produces a 32-bit word, with clear.
- FSM, PC and handshake stay in ifetch_align.

Test Plan:
- Reset with memory 0x00:13,0x01:05,0x02:00,0x03:00, ready=1 -> after 5 edges: instr_valid=1, instr=32'h00000513, instr_pc=0x00, instr_c=0; next pc 0x04.
- Memory 0x04:01,0x05:45 (c.li) -> instr=32'h00004501, instr_c=1, instr_pc=0x04, valid on the 3rd edge; next fetch address 0x06.
- Hold instr_ready=0 for 4 cycles in HOLD -> outputs stable, imem_oe=0, pc unchanged; ready=1 -> valid drops next cycle and imem_addr=pc+len.
- redirect_valid=1, redirect_pc=0x21 during B2 of a 32-bit fetch -> partial instruction dropped, next imem_addr=0x20, no valid until the new instruction completes. Repeat during HOLD with instr_ready=1 -> redirect wins, pc=0x20.
- 32-bit instruction at 0xFE (bytes 0xFE=0x93,0xFF=0x00,0x00=0x10,0x01=0x00) -> addresses 0xFE,0xFF,0x00,0x01, instr=32'h00100093, next pc 0x02.
- Assert reset in B1 -> instr_valid=0 and imem_oe=0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
